// File: rtl/mux2_arbiter_if.sv
// mux2_arbiter_if: requester, downstream and status signals of the two-way packet arbiter
interface mux2_arbiter_if #(parameter int WIDTH = 8);
  logic             req_a;
  logic [WIDTH-1:0] dat_a;
  logic             last_a;
  logic             req_b;
  logic [WIDTH-1:0] dat_b;
  logic             last_b;
  logic             gnt_a;
  logic             gnt_b;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
  logic             sel;
  logic             busy;
  modport slave (
    input  req_a, dat_a, last_a, req_b, dat_b, last_b, out_ready,
    output gnt_a, gnt_b, out_valid, out_data, sel, busy
  );
  modport master (
    output req_a, dat_a, last_a, req_b, dat_b, last_b, out_ready,
    input  gnt_a, gnt_b, out_valid, out_data, sel, busy
  );
endinterface

// File: rtl/mux2_arbiter.sv
// mux2_arbiter: packet-locked round-robin arbiter muxing two requesters onto one stream
module mux2_arbiter #(parameter int WIDTH = 8) (
  input  logic          clk,
  input  logic          rst_n,
  mux2_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_t;
  state_t           r_state;
  logic             r_sel;
  logic             r_prio;
  logic             w_gnt_a;
  logic             w_gnt_b;
  logic             w_valid;
  logic [WIDTH-1:0] w_data;
  // grants and valid decode from the registered owner, so IDLE never grants
  always_comb begin
    w_gnt_a = r_state == OWN_A && bus.req_a && bus.out_ready;
    w_gnt_b = r_state == OWN_B && bus.req_b && bus.out_ready;
    w_valid = r_state == OWN_A ? bus.req_a : r_state == OWN_B ? bus.req_b : 1'b0;
    w_data  = r_sel ? bus.dat_b : bus.dat_a;
  end
  assign bus.gnt_a     = w_gnt_a;
  assign bus.gnt_b     = w_gnt_b;
  assign bus.out_valid = w_valid;
  assign bus.out_data  = w_data;
  assign bus.sel       = r_sel;
  assign bus.busy      = r_state != IDLE;
  // ownership FSM: arbitrate in IDLE, hold until the owner's last beat, then hand over without a bubble
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_sel   <= 1'b0;
      r_prio  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.req_a && (!bus.req_b || !r_prio)) begin
            r_state <= OWN_A;
            r_sel   <= 1'b0;
          end else if (bus.req_b) begin
            r_state <= OWN_B;
            r_sel   <= 1'b1;
          end
        end
        OWN_A: begin
          if (w_gnt_a && bus.last_a) begin
            r_prio <= 1'b1;
            if (bus.req_b) begin
              r_state <= OWN_B;
              r_sel   <= 1'b1;
            end else begin
              r_state <= IDLE;
            end
          end
        end
        OWN_B: begin
          if (w_gnt_b && bus.last_b) begin
            r_prio <= 1'b0;
            if (bus.req_a) begin
              r_state <= OWN_A;
              r_sel   <= 1'b0;
            end else begin
              r_state <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mux2_arbiter.sv
// tb_mux2_arbiter: scoreboard bench for the two-way packet arbiter
module tb_mux2_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  mux2_arbiter_if #(.WIDTH(8)) bus ();
  mux2_arbiter #(.WIDTH(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  always #5 clk = ~clk;
  int n_vec = 0;
  int n_err = 0;
  logic [8:0] q[$];
  logic a_on, b_on, g_a, g_b;
  int a_len, b_len, a_beat, b_beat;
  logic [7:0] a_seq, b_seq, a_base, b_base;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask
  task automatic drive();
    bus.req_a  = a_on;
    bus.dat_a  = a_base + a_seq;
    bus.last_a = a_beat == a_len - 1;
    bus.req_b  = b_on;
    bus.dat_b  = b_base + b_seq;
    bus.last_b = b_beat == b_len - 1;
  endtask
  task automatic sample();
    logic [8:0] e;
    @(negedge clk);
    g_a = bus.gnt_a;
    g_b = bus.gnt_b;
    chk("mutex", {31'd0, bus.gnt_a & bus.gnt_b}, 0);
    chk("mux", {24'd0, bus.out_data}, {24'd0, bus.sel ? bus.dat_b : bus.dat_a});
    if (g_a | g_b) begin
      chk("gnt_valid", {31'd0, bus.out_valid}, 1);
      if (q.size() == 0) chk("unexp_beat", {23'd0, g_b, bus.out_data}, 32'hFFFF_FFFF);
      else begin
        e = q.pop_front();
        chk("beat", {23'd0, g_b, bus.out_data}, {23'd0, e});
      end
    end
  endtask
  task automatic adv();
    @(posedge clk);
    #1;
    if (g_a) begin
      a_seq++;
      a_beat = bus.last_a ? 0 : a_beat + 1;
    end
    if (g_b) begin
      b_seq++;
      b_beat = bus.last_b ? 0 : b_beat + 1;
    end
    drive();
  endtask
  task automatic tick();
    sample();
    adv();
  endtask
  task automatic do_reset(input string tag);
    chk({tag, "_sb_left"}, q.size(), 0);
    q.delete();
    rst_n = 1'b0;
    #1;
    chk({tag, "_rst_busy"}, {31'd0, bus.busy}, 0);
    chk({tag, "_rst_valid"}, {31'd0, bus.out_valid}, 0);
    chk({tag, "_rst_gnt"}, {30'd0, bus.gnt_a, bus.gnt_b}, 0);
    chk({tag, "_rst_sel"}, {31'd0, bus.sel}, 0);
    a_on = 0; b_on = 0; a_seq = 0; b_seq = 0; a_beat = 0; b_beat = 0;
    a_base = 8'hA0; b_base = 8'hB0; g_a = 0; g_b = 0;
    bus.out_ready = 1'b1;
    drive();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask
  initial begin
    a_len = 2; b_len = 2;
    do_reset("init");
    // alternation with both requesting and 2-beat packets
    a_on = 1; b_on = 1; drive();
    q.push_back({1'b0, 8'hA0}); q.push_back({1'b0, 8'hA1});
    q.push_back({1'b1, 8'hB0}); q.push_back({1'b1, 8'hB1});
    q.push_back({1'b0, 8'hA2}); q.push_back({1'b0, 8'hA3});
    sample();
    chk("alt_bubble", {31'd0, bus.out_valid}, 0);
    adv();
    for (int i = 0; i < 6; i++) begin
      sample();
      chk("alt_gnt", {30'd0, bus.gnt_a, bus.gnt_b}, (i == 2 || i == 3) ? 1 : 2);
      if (i == 5) begin a_on = 0; b_on = 0; end
      adv();
    end
    // single-beat packet from B alone
    do_reset("single");
    b_base = 8'h5A; b_len = 1; b_on = 1; drive();
    q.push_back({1'b1, 8'h5A});
    sample();
    chk("single_bubble", {30'd0, bus.gnt_a, bus.gnt_b}, 0);
    adv();
    sample();
    chk("single_sel", {31'd0, bus.sel}, 1);
    chk("single_data", {24'd0, bus.out_data}, 32'h5A);
    chk("single_gnt", {31'd0, bus.gnt_b}, 1);
    b_on = 0;
    adv();
    sample();
    chk("single_idle", {30'd0, bus.busy, bus.out_valid}, 0);
    adv();
    // out_ready stall in OWN_A
    do_reset("stall");
    a_len = 4; b_len = 2; a_on = 1; drive();
    for (int i = 0; i < 4; i++) q.push_back({1'b0, 8'hA0 + 8'(i)});
    tick();
    tick();
    bus.out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      sample();
      chk("stall_gnt", {31'd0, bus.gnt_a}, 0);
      chk("stall_valid", {31'd0, bus.out_valid}, 1);
      chk("stall_data", {24'd0, bus.out_data}, 32'hA1);
      adv();
    end
    bus.out_ready = 1;
    sample();
    chk("stall_resume", {31'd0, bus.gnt_a}, 1);
    adv();
    tick();
    sample();
    a_on = 0;
    adv();
    sample();
    chk("stall_idle", {31'd0, bus.busy}, 0);
    adv();
    // owner drops req mid-packet while B waits
    do_reset("drop");
    a_len = 3; b_len = 1; a_on = 1; b_on = 1; drive();
    q.push_back({1'b0, 8'hA0}); q.push_back({1'b0, 8'hA1});
    q.push_back({1'b0, 8'hA2}); q.push_back({1'b1, 8'hB0});
    tick();
    tick();
    a_on = 0; drive();
    for (int i = 0; i < 2; i++) begin
      sample();
      chk("drop_sel", {31'd0, bus.sel}, 0);
      chk("drop_gnt", {30'd0, bus.gnt_a, bus.gnt_b}, 0);
      chk("drop_valid", {30'd0, bus.busy, bus.out_valid}, 2);
      adv();
    end
    a_on = 1; drive();
    tick();
    sample();
    a_on = 0;
    adv();
    sample();
    chk("drop_b_sel", {31'd0, bus.sel}, 1);
    b_on = 0;
    adv();
    sample();
    chk("drop_idle", {31'd0, bus.busy}, 0);
    adv();
    // asynchronous reset mid-packet in OWN_B, then A wins first
    do_reset("midb");
    a_len = 2; b_len = 3; a_on = 1; b_on = 1; drive();
    q.push_back({1'b0, 8'hA0}); q.push_back({1'b0, 8'hA1}); q.push_back({1'b1, 8'hB0});
    tick();
    tick();
    tick();
    sample();
    chk("midb_owner", {31'd0, bus.gnt_b}, 1);
    do_reset("midb_async");
    a_len = 2; b_len = 2; a_on = 1; b_on = 1; drive();
    q.push_back({1'b0, 8'hA0}); q.push_back({1'b0, 8'hA1});
    sample();
    chk("after_rst_bubble", {30'd0, bus.gnt_a, bus.gnt_b}, 0);
    adv();
    sample();
    chk("after_rst_a_first", {30'd0, bus.gnt_a, bus.gnt_b}, 2);
    adv();
    sample();
    a_on = 0; b_on = 0;
    adv();
    do_reset("end");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
